// File: rtl/logic_unit_seq.sv
// Registered eight-function bitwise logic unit with valid/ready handshake and built-in truth-table sweep.
// Optional: define LOGIC_UNIT_SEQ_FAULT_INJECT_EN to add fault_inj, which inverts result bit 0.
module logic_unit_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic             sweep_err
`ifdef LOGIC_UNIT_SEQ_FAULT_INJECT_EN
    ,
    input  logic             fault_inj
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SWEEP,
        DONE
    } state_t;

    // Golden truth tables packed op-major, so bit index {op, a, b} equals the sweep count.
    localparam logic [31:0] GOLDEN = {
        4'b0010,  // 7 ANDN
        4'b1001,  // 6 XNOR
        4'b0110,  // 5 XOR
        4'b0001,  // 4 NOR
        4'b0111,  // 3 NAND
        4'b0011,  // 2 NOT A
        4'b1110,  // 1 OR
        4'b1000   // 0 AND
    };

    state_t           state, state_next;
    logic [4:0]       cnt;
    logic [2:0]       dp_op;
    logic [WIDTH-1:0] dp_a, dp_b, dp_res;
    logic             in_fire;

    // The sweep borrows the single datapath; normal beats cannot arrive then since in_ready is low.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dp_op  = op;
        dp_a   = a;
        dp_b   = b;
        dp_res = '0;
        if (state == SWEEP) begin
            dp_op = cnt[4:2];
            dp_a  = {WIDTH{cnt[1]}};
            dp_b  = {WIDTH{cnt[0]}};
        end
        case (dp_op)
            3'd0:    dp_res = dp_a & dp_b;
            3'd1:    dp_res = dp_a | dp_b;
            3'd2:    dp_res = ~dp_a;
            3'd3:    dp_res = ~(dp_a & dp_b);
            3'd4:    dp_res = ~(dp_a | dp_b);
            3'd5:    dp_res = dp_a ^ dp_b;
            3'd6:    dp_res = ~(dp_a ^ dp_b);
            3'd7:    dp_res = ~dp_a & dp_b;
            default: dp_res = '0;
        endcase
`ifdef LOGIC_UNIT_SEQ_FAULT_INJECT_EN
        if (fault_inj) dp_res[0] = ~dp_res[0];
`endif
    end

    assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
    assign in_fire    = in_valid && in_ready;
    assign sweep_busy = (state != IDLE);
    assign sweep_done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sweep_start) state_next = out_valid ? DRAIN : SWEEP;
            DRAIN:   if (!out_valid) state_next = SWEEP;
            SWEEP:   if (cnt == 5'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register reading pre-edge values.
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            sweep_err <= 1'b0;
        end else begin
            state <= state_next;

            if (in_fire) begin
                y         <= dp_res;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (state == IDLE && sweep_start) sweep_err <= 1'b0;

            if (state == SWEEP) begin
                cnt <= cnt + 5'd1;
                if (dp_res != {WIDTH{GOLDEN[cnt]}}) sweep_err <= 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule
